ttl_word_shifter_sync: RTL and testbench

Parametrised multi-stage word register: a chain of DEPTH hex-D-style stages, WIDTH bits each, all updated on a single system clock and qualified by the Cen strobe. It generalises the single-stage 74174-style latch with selectable hold, shift-up, shift-down and broadcast-load modes, plus per-stage valid tracking. Used wherever board logic chains 74174s as delay lines, shift registers or scroll/line buffers clocked from a divided pixel clock.

---
 rtl/ttl_word_shifter_sync_if.sv | 25 ++
 rtl/ttl_word_shifter_sync.sv | 90 +++++++++
 tb/tb_ttl_word_shifter_sync.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ttl_word_shifter_sync_if.sv
// Bus bundle for ttl_word_shifter_sync: strobe, mode and data in; stage words and status out.
interface ttl_word_shifter_sync_if #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
);
  logic                   Cen;
  logic [1:0]             Mode;
  logic [WIDTH-1:0]       D;
  logic [DEPTH*WIDTH-1:0] Q;
  logic [WIDTH-1:0]       Q_first;
  logic [WIDTH-1:0]       Q_last;
  logic [DEPTH-1:0]       Valid;
  logic                   Full;
  logic                   Act;

  modport master (
    output Cen, Mode, D,
    input  Q, Q_first, Q_last, Valid, Full, Act
  );

  modport slave (
    input  Cen, Mode, D,
    output Q, Q_first, Q_last, Valid, Full, Act
  );
endinterface

// File: rtl/ttl_word_shifter_sync.sv
// Chain of DEPTH WIDTH-bit 74174-style stages with hold/shift-up/shift-down/broadcast modes.
// Define TTL_SYNC_CEN_EDGE_EN to update on Cen rising edges; otherwise Cen is a plain level enable.
module ttl_word_shifter_sync #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                   Clk,
  input  logic                   Clr_n,
  ttl_word_shifter_sync_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_BCAST = 2'b11
  } mode_e;

  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic                        act_q;
  logic                        upd;
  mode_e                       mode;

  assign mode = mode_e'(bus.Mode);

`ifdef TTL_SYNC_CEN_EDGE_EN
  logic last_cen_q;

  assign upd = bus.Cen & ~last_cen_q;

  // Reset value 1 keeps a Cen already high at release from counting as an edge.
  always_ff @(posedge Clk) begin
    if (!Clr_n) last_cen_q <= 1'b1;
    else        last_cen_q <= bus.Cen;
  end
`else
  assign upd = bus.Cen;
`endif

  always_comb begin
    stage_d = stage_q;
    valid_d = valid_q;
    if (upd) begin
      case (mode)
        MODE_UP: begin
          for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
            valid_d[i] = valid_q[i-1];
          end
          stage_d[0] = bus.D;
          valid_d[0] = 1'b1;
        end
        MODE_DOWN: begin
          for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            stage_d[i] = stage_q[i+1];
            valid_d[i] = valid_q[i+1];
          end
          stage_d[DEPTH-1] = bus.D;
          valid_d[DEPTH-1] = 1'b1;
        end
        MODE_BCAST: begin
          stage_d = {DEPTH{bus.D}};
          valid_d = '1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clr_n) begin
      stage_q <= '0;
      valid_q <= '0;
      act_q   <= 1'b0;
    end else begin
      stage_q <= stage_d;
      valid_q <= valid_d;
      act_q   <= upd;
    end
  end

  assign bus.Q       = stage_q;
  assign bus.Q_first = stage_q[0];
  assign bus.Q_last  = stage_q[DEPTH-1];
  assign bus.Valid   = valid_q;
  assign bus.Full    = &valid_q;
  assign bus.Act     = act_q;

endmodule

// File: tb/tb_ttl_word_shifter_sync.sv
// Directed bench for ttl_word_shifter_sync: queue-based reference model checked every cycle plus literal spot checks.
module tb_ttl_word_shifter_sync;
  localparam int W = 6;
  localparam int N = 4;

  logic Clk = 1'b0;
  logic Clr_n;
  int   vectors = 0;
  int   miscompares = 0;

  ttl_word_shifter_sync_if #(.WIDTH(W), .DEPTH(N)) bus ();

  ttl_word_shifter_sync #(.WIDTH(W), .DEPTH(N)) dut (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Reference model: stage 0 at queue front, words move as whole entries.
  int unsigned m_q[$];
  bit          m_v[$];
  bit          m_act;
  bit          m_last;
  bit          m_ready = 1'b0;

  always @(posedge Clk) begin
    bit upd;
    if (!Clr_n) begin
      m_q.delete(); m_v.delete();
      for (int i = 0; i < N; i++) begin m_q.push_back(0); m_v.push_back(1'b0); end
      m_act  = 1'b0;
      m_last = 1'b1;
      m_ready = 1'b1;
    end else if (m_ready) begin
`ifdef TTL_SYNC_CEN_EDGE_EN
      upd = bus.Cen && !m_last;
`else
      upd = bus.Cen;
`endif
      m_last = bus.Cen;
      m_act  = upd;
      if (upd) begin
        case (bus.Mode)
          2'b01: begin
            m_q.push_front(int'(bus.D)); void'(m_q.pop_back());
            m_v.push_front(1'b1);        void'(m_v.pop_back());
          end
          2'b10: begin
            m_q.push_back(int'(bus.D)); void'(m_q.pop_front());
            m_v.push_back(1'b1);        void'(m_v.pop_front());
          end
          2'b11: for (int i = 0; i < N; i++) begin m_q[i] = int'(bus.D); m_v[i] = 1'b1; end
          default: ;
        endcase
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    logic [N*W-1:0] eq;
    logic [N-1:0]   ev;
    bit             all;
    if (m_ready) begin
      all = 1'b1;
      for (int i = 0; i < N; i++) begin
        eq[i*W +: W] = m_q[i][W-1:0];
        ev[i] = m_v[i];
        all &= m_v[i];
      end
      cmp("model_Q",       64'(bus.Q),       64'(eq));
      cmp("model_Q_first", 64'(bus.Q_first), 64'(m_q[0]));
      cmp("model_Q_last",  64'(bus.Q_last),  64'(m_q[N-1]));
      cmp("model_Valid",   64'(bus.Valid),   64'(ev));
      cmp("model_Full",    64'(bus.Full),    64'(all));
      cmp("model_Act",     64'(bus.Act),     64'(m_act));
    end
  end

  task automatic step(input logic c, input logic [1:0] m, input logic [W-1:0] d);
    bus.Cen = c; bus.Mode = m; bus.D = d;
    @(posedge Clk); #1;
  endtask

  task automatic strobe(input logic [1:0] m, input logic [W-1:0] d);
    step(1'b0, m, d);
    step(1'b1, m, d);
  endtask

  task automatic do_reset();
    Clr_n = 1'b0;
    step(1'b0, 2'b00, '0);
    Clr_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    Clr_n = 1'b0;
    bus.Cen = 1'b0; bus.Mode = 2'b11; bus.D = 6'h3F;

    // Reset with Cen toggling and broadcast requested
    step(1'b1, 2'b11, 6'h3F);
    step(1'b0, 2'b11, 6'h3F);
    cmp("rst_Q",     64'(bus.Q),     64'h0);
    cmp("rst_Valid", 64'(bus.Valid), 64'h0);
    cmp("rst_Act",   64'(bus.Act),   64'h0);
    cmp("rst_Full",  64'(bus.Full),  64'h0);
    Clr_n = 1'b1;
    step(1'b1, 2'b11, 6'h3F);
`ifdef TTL_SYNC_CEN_EDGE_EN
    cmp("release_high_Q",   64'(bus.Q),   64'h0);
    cmp("release_high_Act", 64'(bus.Act), 64'h0);
`endif
    strobe(2'b11, 6'h3F);
    cmp("release_strobe_Valid", 64'(bus.Valid), 64'hF);
    cmp("release_strobe_Q",     64'(bus.Q),     64'hFFFFFF);

    // Shift up through and past a full chain
    do_reset();
    for (int k = 1; k <= 4; k++) strobe(2'b01, W'(k));
    cmp("up_Q_first", 64'(bus.Q_first), 64'h04);
    cmp("up_Q_last",  64'(bus.Q_last),  64'h01);
    cmp("up_Valid",   64'(bus.Valid),   64'hF);
    cmp("up_Full",    64'(bus.Full),    64'h1);
    strobe(2'b01, 6'h05);
    cmp("up5_Q_last", 64'(bus.Q_last), 64'h02);
    cmp("up5_Full",   64'(bus.Full),   64'h1);

    // Shift down from empty
    do_reset();
    strobe(2'b10, 6'h0A);
    strobe(2'b10, 6'h0B);
    cmp("down_stage3", 64'(bus.Q[3*W +: W]), 64'h0B);
    cmp("down_stage2", 64'(bus.Q[2*W +: W]), 64'h0A);
    cmp("down_Valid",  64'(bus.Valid),      64'hC);
    cmp("down_Full",   64'(bus.Full),       64'h0);

    // Broadcast, then hold with different D
    strobe(2'b11, 6'h15);
    cmp("bcast_Q",     64'(bus.Q),     64'h555555);
    cmp("bcast_Valid", 64'(bus.Valid), 64'hF);
    strobe(2'b00, 6'h2A);
    cmp("hold_Q",   64'(bus.Q),   64'h555555);
    cmp("hold_Act", 64'(bus.Act), 64'h1);
    step(1'b0, 2'b00, 6'h2A);
    cmp("hold_Act_drop", 64'(bus.Act), 64'h0);

    // Mode/D changes with Cen low must be ignored
    step(1'b0, 2'b01, 6'h01);
    step(1'b0, 2'b10, 6'h02);
    step(1'b0, 2'b11, 6'h03);
    cmp("idle_Q", 64'(bus.Q), 64'h555555);

    // Cen held high for five cycles
    do_reset();
    step(1'b0, 2'b01, 6'h00);
    pulses = 0;
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 2'b01, W'(k));
      if (bus.Act) pulses++;
    end
    step(1'b0, 2'b01, 6'h00);
    if (bus.Act) pulses++;
`ifdef TTL_SYNC_CEN_EDGE_EN
    cmp("held_pulses", 64'(pulses),    64'd1);
    cmp("held_Valid",  64'(bus.Valid), 64'h1);
    cmp("held_Q_first", 64'(bus.Q_first), 64'h01);
`else
    cmp("held_pulses", 64'(pulses),    64'd5);
    cmp("held_Valid",  64'(bus.Valid), 64'hF);
    cmp("held_Q_first", 64'(bus.Q_first), 64'h05);
`endif

    // Reset coincident with an update
    strobe(2'b01, 6'h09);
    step(1'b0, 2'b11, 6'h3F);
    Clr_n = 1'b0;
    step(1'b1, 2'b11, 6'h3F);
    cmp("rst_upd_Q",     64'(bus.Q),     64'h0);
    cmp("rst_upd_Valid", 64'(bus.Valid), 64'h0);
    cmp("rst_upd_Act",   64'(bus.Act),   64'h0);
    Clr_n = 1'b1;
    step(1'b0, 2'b00, 6'h00);
    step(1'b0, 2'b00, 6'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
